// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: UART receiver, serial-in / parallel-out, LSB first.
// The asynchronous rx line passes through a two-flop synchronizer. A 1->0 edge
// on the synchronized line starts a frame. Each bit is sampled once at mid-bit.
// The received word appears on data_out with a one-cycle rx_valid strobe.
// Optional feature macro: UART_RX_PARITY_CHECK_EN
//   - When defined, an even-parity bit is expected between the last data bit and
//     the stop bit.
//   - When undefined, the PARITY state does not exist and parity_err is constant 0.
module uart_rx_sipo #(
    parameter int W_DATA       = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              rx,
    output logic [W_DATA-1:0] data_out,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (W_DATA > 1) ? $clog2(W_DATA) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W_DATA - 1);

`ifdef UART_RX_PARITY_CHECK_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity: XOR of all data bits, which equals the expected parity bit.
    function automatic logic parity_even(input logic [W_DATA-1:0] d);
        parity_even = ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t              state_r, state_nxt;
    logic                rx_meta_r, rx_s_r, rx_s_d_r;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt;
    logic [BIT_W-1:0]    bit_r, bit_nxt;
    logic [W_DATA-1:0]   shift_r, shift_nxt;
    logic                p_bad_r, p_bad_nxt;
    logic [W_DATA-1:0]   data_r, data_nxt;
    logic                valid_r, valid_nxt;
    logic                ferr_r, ferr_nxt;
    logic                perr_r, perr_nxt;
    logic                busy_r;

    assign data_out   = data_r;
    assign rx_valid   = valid_r;
    assign frame_err  = ferr_r;
    assign parity_err = perr_r;
    assign busy       = busy_r;

    // Two-flop synchronizer on rx, plus one more delayed copy for start-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
            rx_s_d_r  <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
            rx_s_d_r  <= rx_s_r;
        end
    end

    // FSM state register; busy mirrors "not IDLE" from the same next-state value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            busy_r  <= (state_nxt != IDLE);
        end
    end

    // Next-state, counter, shift and output-pulse logic.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        bit_nxt   = bit_r;
        shift_nxt = shift_r;
        p_bad_nxt = p_bad_r;
        data_nxt  = data_r;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        perr_nxt  = 1'b0;

        if (!enb) begin
            // A low enable aborts any frame. The partly shifted word is kept.
            state_nxt = IDLE;
            cnt_nxt   = {CNT_W{1'b0}};
            bit_nxt   = {BIT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_nxt = {CNT_W{1'b0}};
                    bit_nxt = {BIT_W{1'b0}};
                    // A frame starts only on a 1->0 edge, so a held-low line cannot re-trigger.
                    if (rx_s_d_r && !rx_s_r) begin
                        state_nxt = START;
                        p_bad_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                START: begin
                    if (cnt_r == CNT_MID) begin
                        cnt_nxt = {CNT_W{1'b0}};
                        // If the line is high at mid start bit, the low was only a glitch.
                        if (!rx_s_r) begin
                            state_nxt = DATA;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt   = {CNT_W{1'b0}};
                        shift_nxt = {rx_s_r, shift_r[W_DATA-1:1]};
                        if (bit_r == BIT_LAST) begin
                            bit_nxt = {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_CHECK_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end else begin
                            bit_nxt = bit_r + BIT_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_CHECK_EN
                PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt   = {CNT_W{1'b0}};
                        p_bad_nxt = rx_s_r ^ parity_even(shift_r);
                        state_nxt = STOP;
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        // Return to IDLE at mid stop bit. This leaves half a bit to catch a
                        // back-to-back start edge.
                        cnt_nxt   = {CNT_W{1'b0}};
                        state_nxt = IDLE;
                        if (!rx_s_r) begin
                            ferr_nxt = 1'b1;
                        end else if (p_bad_r) begin
                            perr_nxt = 1'b1;
                        end else begin
                            valid_nxt = 1'b1;
                            data_nxt  = shift_r;
                        end
                    end else begin
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = {CNT_W{1'b0}};
                    bit_nxt   = {BIT_W{1'b0}};
                end
            endcase
        end
    end

    // Datapath and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            shift_r <= {W_DATA{1'b0}};
            p_bad_r <= 1'b0;
            data_r  <= {W_DATA{1'b0}};
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            perr_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt;
            bit_r   <= bit_nxt;
            shift_r <= shift_nxt;
            p_bad_r <= p_bad_nxt;
            data_r  <= data_nxt;
            valid_r <= valid_nxt;
            ferr_r  <= ferr_nxt;
            perr_r  <= perr_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo with CLKS_PER_BIT=16. A bit-level line model
// drives rx. A negedge monitor counts output pulses.
module tb_uart_rx_sipo;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       enb;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int total_cnt;
    int bad_cnt;

    int valid_cnt;
    int ferr_cnt;
    int perr_cnt;
    int busy_cyc;
    int excl_viol;
    int prev_any;
    logic [7:0] cap_mem [0:31];

    uart_rx_sipo #(.W_DATA(8), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .rx         (rx),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts strobes, captures words, flags overlap or back-to-back pulses.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            valid_cnt = 0;
            ferr_cnt  = 0;
            perr_cnt  = 0;
            busy_cyc  = 0;
            excl_viol = 0;
            prev_any  = 0;
        end else begin
            if (rx_valid) begin
                cap_mem[valid_cnt[4:0]] = data_out;
                valid_cnt = valid_cnt + 1;
            end
            if (frame_err)  ferr_cnt = ferr_cnt + 1;
            if (parity_err) perr_cnt = perr_cnt + 1;
            if (busy)       busy_cyc = busy_cyc + 1;
            if ((int'(rx_valid) + int'(frame_err) + int'(parity_err)) > 1)
                excl_viol = excl_viol + 1;
            if ((rx_valid || frame_err || parity_err) && prev_any != 0)
                excl_viol = excl_viol + 1;
            prev_any = (rx_valid || frame_err || parity_err) ? 1 : 0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_CHECK_EN
        send_bit(par);
`else
        if (par === 1'bx) rx = 1'b1; // parity bit not part of the frame in this build
`endif
        send_bit(stop_b);
        rx = 1'b1;
    endtask

    int v0, f0, p0, b0;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b0;
        enb = 1'b1;
        rx  = 1'b1;
        idle_clks(5);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        idle_clks(100);

        // 1: idle after reset
        check_val("idle_data",  {24'd0, data_out}, 32'h00);
        check_val("idle_valid", {31'd0, rx_valid}, 32'd0);
        check_val("idle_ferr",  {31'd0, frame_err}, 32'd0);
        check_val("idle_perr",  {31'd0, parity_err}, 32'd0);
        check_val("idle_busy",  {31'd0, busy}, 32'd0);

        // 2: single frame 0xA5
        b0 = busy_cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_clks(20);
        check_val("a5_valid_cnt", valid_cnt, 32'd1);
        check_val("a5_cap",       {24'd0, cap_mem[0]}, 32'hA5);
        check_val("a5_data",      {24'd0, data_out}, 32'hA5);
        check_val("a5_busy_seen", {31'd0, (busy_cyc > b0)}, 32'd1);
        check_val("a5_busy_end",  {31'd0, busy}, 32'd0);

        // 3: back-to-back 0x3C, 0xC3
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle_clks(20);
        check_val("b2b_valid_cnt", valid_cnt, 32'd3);
        check_val("b2b_first",     {24'd0, cap_mem[1]}, 32'h3C);
        check_val("b2b_second",    {24'd0, cap_mem[2]}, 32'hC3);
        check_val("b2b_data",      {24'd0, data_out}, 32'hC3);

        // 4: 4-clock low glitch gives a false start
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt; b0 = busy_cyc;
        rx = 1'b0;
        idle_clks(4);
        rx = 1'b1;
        idle_clks(40);
        check_val("glitch_busy_seen", {31'd0, (busy_cyc > b0)}, 32'd1);
        check_val("glitch_busy_end",  {31'd0, busy}, 32'd0);
        check_val("glitch_pulses",    (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0), 32'd0);

        // 5: 0x55 with stop bit low
        send_frame(8'h55, 1'b0, 1'b0);
        idle_clks(20);
        check_val("ferr_cnt",   ferr_cnt - f0, 32'd1);
        check_val("ferr_valid", valid_cnt - v0, 32'd0);
        check_val("ferr_data",  {24'd0, data_out}, 32'hC3);

        // enable dropped mid-frame: abort, no pulses
        v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        enb = 1'b0;
        idle_clks(3);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        idle_clks(40);
        enb = 1'b1;
        idle_clks(20);
        check_val("abort_pulses", (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0), 32'd0);
        check_val("abort_data",   {24'd0, data_out}, 32'hC3);

`ifdef UART_RX_PARITY_CHECK_EN
        // 6: parity error, then correct parity
        v0 = valid_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        idle_clks(20);
        check_val("par_bad_perr",  perr_cnt - p0, 32'd1);
        check_val("par_bad_valid", valid_cnt - v0, 32'd0);
        check_val("par_bad_data",  {24'd0, data_out}, 32'hC3);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_clks(20);
        check_val("par_ok_valid", valid_cnt - v0, 32'd1);
        check_val("par_ok_data",  {24'd0, data_out}, 32'h07);
        check_val("par_ok_perr",  perr_cnt - p0, 32'd1);
`else
        check_val("perr_never", perr_cnt, 32'd0);
`endif

        check_val("pulse_excl", excl_viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
